// File: rtl/uart_pkg.sv
// uart_pkg: shared types and register map constants for the MMIO UART transmitter.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_BAUD   = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;
   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push on full is accepted only alongside a pop.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic wr, rd;
   assign rd    = pop & ~empty;
   assign wr    = push & (~full | rd);
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem[head];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr) tail <= tail + AW'(1);
         if (rd) head <= head + AW'(1);
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   always_ff @(posedge clk)
      if (wr) mem[tail] <= din;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: data-bus mapped 8N1 UART transmitter with TX FIFO, baud divider and idle interrupt.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          DEPTH       = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic        RE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        tx,
   output logic        irq
);
   logic sel, push, pop, full, empty, ovf, ie, bit_end, busy, unused;
   logic [1:0] off;
   logic [7:0] head, shift;
   logic [15:0] div, div_q, baud_cnt;
   logic [2:0] bit_idx;
   logic [$clog2(DEPTH):0] count;
   logic [31:0] status;
   tx_state_t state;
   assign sel     = A[31:4] == BASE_ADDR[31:4];
   assign off     = A[3:2];
   assign push    = WE & sel & off == OFF_TXDATA;
   assign busy    = state != IDLE;
   assign bit_end = baud_cnt == div_q;
   // pop from IDLE, or on the last STOP clock so the next frame follows with no gap
   assign pop     = ~empty & (state == IDLE | (state == STOP & bit_end));
   assign irq     = ie & empty & ~busy;
   assign status  = {23'd0, 5'(count), ovf, empty, full, busy};
   assign RD      = !(sel & RE)          ? 32'd0 :
                    off == OFF_STATUS    ? status :
                    off == OFF_BAUD      ? {16'd0, div} :
                    off == OFF_CTRL      ? {31'd0, ie} : 32'd0;
   assign unused  = ^{A[1:0], WD[31:16]};
   sync_fifo #(.DATA_W(8), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(WD[7:0]),
      .dout(head), .full(full), .empty(empty), .count(count)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div <= DEFAULT_DIV;
         ie  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         if (WE & sel & off == OFF_BAUD) div <= WD[15:0];
         if (WE & sel & off == OFF_CTRL) ie <= WD[0];
         ovf <= (push & full & ~pop) | (ovf & ~(WE & sel & off == OFF_STATUS & WD[ST_OVF]));
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         shift    <= '0;
         div_q    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            IDLE:
               if (!empty) begin
                  shift    <= head;
                  div_q    <= div;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= START;
               end
            START:
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else baud_cnt <= baud_cnt + 16'd1;
            DATA:
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else baud_cnt <= baud_cnt + 16'd1;
            STOP:
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (!empty) begin
                     shift <= head;
                     div_q <= div;
                     tx    <= 1'b0;
                     state <= START;
                  end else state <= IDLE;
               end else baud_cnt <= baud_cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus against a frame-timeline model of the UART transmitter.
module tb_mmio_uart_tx;
   localparam int DEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0, WE = 1'b0, RE = 1'b0;
   logic [31:0] A = '0, WD = '0, RD;
   logic tx, irq;
   int n_chk = 0, n_fail = 0;

   mmio_uart_tx #(.BASE_ADDR(32'h0000_1000), .DEPTH(DEPTH), .DEFAULT_DIV(16'd15)) dut (
      .clk(clk), .rst(rst_n), .WE(WE), .RE(RE), .A(A), .WD(WD), .RD(RD), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   // model: byte queue plus the current frame as (start offset, byte, divider)
   logic [7:0] m_q[$];
   logic [7:0] m_byte = '0;
   bit m_active = 0, m_ie = 0, m_ovf = 0, ms, mp, me;
   int m_pos = 0, m_fdiv = 0, m_div = 15;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         m_active = 0; m_pos = 0; m_fdiv = 0; m_div = 15; m_ie = 0; m_ovf = 0;
      end else begin
         ms = A[31:4] == 28'h000_0100;
         me = m_active && m_pos == 10 * (m_fdiv + 1) - 1;
         mp = m_q.size() > 0 && (!m_active || me);
         if (mp) begin
            m_byte = m_q.pop_front(); m_fdiv = m_div; m_pos = 0; m_active = 1;
         end else if (me) m_active = 0;
         else if (m_active) m_pos++;
         if (WE && ms)
            case (A[3:2])
               2'd0: if (m_q.size() < DEPTH) m_q.push_back(WD[7:0]); else m_ovf = 1;
               2'd1: if (WD[3]) m_ovf = 0;
               2'd2: m_div = int'(WD[15:0]);
               default: m_ie = WD[0];
            endcase
      end
   end

   function automatic logic m_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_pos / (m_fdiv + 1);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_byte[k-1];
   endfunction

   function automatic logic [31:0] m_rd();
      if (!(RE && A[31:4] == 28'h000_0100)) return 32'd0;
      case (A[3:2])
         2'd1: return {23'd0, 5'(m_q.size()), m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_active};
         2'd2: return {16'd0, 16'(m_div)};
         2'd3: return {31'd0, m_ie};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      chk("model_tx", {31'd0, tx}, {31'd0, m_tx()});
      chk("model_irq", {31'd0, irq}, {31'd0, m_ie && m_q.size() == 0 && !m_active});
      chk("model_rd", RD, m_rd());
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      WE = 1'b1; A = a; WD = d;
      @(posedge clk); #2;
      WE = 1'b0; A = '0; WD = '0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      RE = 1'b1; A = a;
      @(negedge clk);
      chk(nm, RD, exp);
      @(posedge clk); #2;
      RE = 1'b0; A = '0;
   endtask

   task automatic wait_idle(input int lim);
      int i = 0;
      while ((m_active || m_q.size() > 0) && i < lim) begin step(1); i++; end
      chk("idle_timeout", {31'd0, m_active || m_q.size() > 0}, 32'd0);
   endtask

   logic [9:0] fr;
   logic [19:0] bb;

   initial begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rd", RD, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      step(1);
      rd(32'h1008, 32'h0000_000F, "baud_default");
      rd(32'h1004, 32'h0000_0004, "status_default");
      // single 0xA5 frame at 4 clocks per bit
      wr(32'h1008, 32'd3);
      wr(32'h1000, 32'h0000_00A5);
      step(1);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("frame_a5", {31'd0, tx}, {31'd0, fr[i/4]});
         @(posedge clk); #2;
      end
      rd(32'h1004, 32'h0000_0004, "status_after_a5");
      // back-to-back frames at 1 clock per bit
      wr(32'h1008, 32'd0);
      wr(32'h1000, 32'h55);
      wr(32'h1000, 32'h0F);
      bb = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("frame_b2b", {31'd0, tx}, {31'd0, bb[i]});
         @(posedge clk); #2;
      end
      rd(32'h1004, 32'h0000_0004, "status_after_b2b");
      // overflow: one byte popped, four queued, sixth dropped
      wr(32'h1008, 32'd100);
      for (int i = 0; i < 6; i++) wr(32'h1000, 32'h10 + i);
      rd(32'h1004, 32'h0000_004B, "status_ovf");
      wr(32'h1004, 32'h8);
      rd(32'h1004, 32'h0000_0043, "status_ovf_clr");
      // push on full exactly at the frame-end pop
      begin
         int i = 0;
         while (!(m_active && m_pos == 10 * (m_fdiv + 1) - 1) && i < 3000) begin step(1); i++; end
         chk("pop_edge_timeout", i, (i < 3000) ? i : -1);
      end
      wr(32'h1000, 32'hC3);
      rd(32'h1004, 32'h0000_0043, "status_full_pop");
      wr(32'h1008, 32'd1);
      wait_idle(20000);
      rd(32'h1004, 32'h0000_0004, "status_drained");
      // decode and interrupt
      rd(32'h2008, 32'd0, "rd_unselected");
      wr(32'h2008, 32'd7);
      rd(32'h1008, 32'd1, "baud_unaffected");
      wr(32'h100C, 32'd1);
      @(negedge clk);
      chk("irq_on", {31'd0, irq}, 32'd1);
      @(posedge clk); #2;
      wr(32'h1000, 32'h3C);
      @(negedge clk);
      chk("irq_busy", {31'd0, irq}, 32'd0);
      @(posedge clk); #2;
      wait_idle(200);
      @(negedge clk);
      chk("irq_frame_end", {31'd0, irq}, 32'd1);
      @(posedge clk); #2;
      // reset in the middle of the data bits
      wr(32'h1000, 32'h00);
      wr(32'h1000, 32'hFF);
      step(5);
      @(negedge clk);
      chk("tx_data_low", {31'd0, tx}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", {31'd0, tx}, 32'd1);
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      rd(32'h1004, 32'h0000_0004, "status_after_rst");
      rd(32'h100C, 32'd0, "ctrl_after_rst");
      rd(32'h1008, 32'h0000_000F, "baud_after_rst");
      step(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
